// File: rtl/ffd_bank_pkg.sv
// Shared types for the ffd_bank storage-channel bank.
package ffd_bank_pkg;

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } ffd_mode_t;

    typedef enum logic {
        CFG_IDLE  = 1'b0,
        CFG_APPLY = 1'b1
    } cfg_state_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_sel_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/ffd_channel.sv
// One configurable D/T/JK/SR storage channel with sticky illegal-SR flag.
// Optional saturating transition counter under FFD_BANK_TOGGLE_CNT_EN.
module ffd_channel
    import ffd_bank_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             apply,
    input  logic [1:0]       apply_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic             err
`ifdef FFD_BANK_TOGGLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    ffd_mode_t        mode;
    logic [WIDTH-1:0] q_next;
    logic             illegal;

    always_comb begin
        q_next  = q;
        illegal = 1'b0;
        case (mode)
            MODE_D:  q_next = a;
            MODE_T:  q_next = q ^ a;
            MODE_JK: q_next = (a & ~q) | (~b & q);
            MODE_SR: begin
                // S=R=1 falls into the hold term, so illegal bits keep their value.
                q_next  = (a & ~b) | (q & ~(a ^ b));
                illegal = |(a & b);
            end
            default: q_next = q;
        endcase
    end

    // Reconfiguration takes priority over enable and data for that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= MODE_D;
            q    <= '0;
            err  <= 1'b0;
        end else if (apply) begin
            mode <= ffd_mode_t'(apply_mode);
            q    <= '0;
            err  <= 1'b0;
        end else if (en) begin
            q <= q_next;
            if (illegal) begin
                err <= 1'b1;
            end
        end
    end

`ifdef FFD_BANK_TOGGLE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (apply) begin
            cnt <= '0;
        end else if (en && (q_next != q) && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ffd_bank.sv
// Bank of CHANNELS configurable flip-flop channels with a two-state config port.
// Optional per-channel transition counters: define FFD_BANK_TOGGLE_CNT_EN.
module ffd_bank
    import ffd_bank_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 1,
    parameter int CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*WIDTH-1:0]     a,
    input  logic [CHANNELS*WIDTH-1:0]     b,
    input  logic [CHANNELS-1:0]           en,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [ch_sel_w(CHANNELS)-1:0] cfg_ch,
    input  logic [1:0]                    cfg_mode,
    output logic [CHANNELS*WIDTH-1:0]     q,
    output logic [CHANNELS-1:0]           err
`ifdef FFD_BANK_TOGGLE_CNT_EN
    ,
    output logic [CHANNELS*CNT_W-1:0]     cnt
`endif
);

    localparam int CH_W = ch_sel_w(CHANNELS);

    cfg_state_t          state;
    cfg_state_t          state_next;
    logic                armed;
    logic                accept;
    logic                apply_active;
    logic [CH_W-1:0]     lat_ch;
    logic [1:0]          lat_mode;
    logic [CHANNELS-1:0] apply;

    // armed keeps cfg_ready low until the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CFG_IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CFG_IDLE:  if (cfg_valid && armed) state_next = CFG_APPLY;
            CFG_APPLY: state_next = CFG_IDLE;
            default:   state_next = CFG_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready    = (state == CFG_IDLE) && armed;
        accept       = cfg_ready && cfg_valid;
        apply_active = (state == CFG_APPLY);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_ch   <= cfg_ch;
            lat_mode <= cfg_mode;
        end
    end

    // Out-of-range selects match no channel, so APPLY passes harmlessly.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign apply[c] = apply_active && (lat_ch == CH_W'(c));

        ffd_channel #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (en[c]),
            .apply      (apply[c]),
            .apply_mode (lat_mode),
            .a          (a[c*WIDTH +: WIDTH]),
            .b          (b[c*WIDTH +: WIDTH]),
            .q          (q[c*WIDTH +: WIDTH]),
            .err        (err[c])
`ifdef FFD_BANK_TOGGLE_CNT_EN
            ,
            .cnt        (cnt[c*CNT_W +: CNT_W])
`endif
        );
    end

endmodule
